blit_cmd_ctrl: RTL and testbench

- Blitter command/status sequencer. Sits directly downstream of the GPU address decoder that produces the blitter register load/read strobes.
- Consumes the cmdld, stopld and statrd strobes together with GPU write data.
- Latches the command word, launches and tracks a blit, and handles collision-stop with resume/abort.
- Presents the status word for GPU readback.

---
 rtl/blit_cmd_ctrl_pkg.sv | 20 ++
 rtl/blit_cmd_ctrl_if.sv | 32 +++
 rtl/blit_cmd_ctrl_run_counter.sv | 34 +++
 rtl/blit_cmd_ctrl.sv | 123 ++++++++++++
 tb/tb_blit_cmd_ctrl.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/blit_cmd_ctrl_pkg.sv
// Shared definitions for the blitter command/status sequencer.
// State encoding, status word bit positions and stop-register bit positions.
package blit_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StStart   = 2'd1,
        StRun     = 2'd2,
        StStopped = 2'd3
    } blit_state_e;

    localparam int unsigned ST_IDLE    = 0;
    localparam int unsigned ST_STOPPED = 1;
    localparam int unsigned ST_OVERRUN = 2;
    localparam int unsigned ST_CNT_LSB = 16;

    localparam int unsigned STOP_RESUME = 0;
    localparam int unsigned STOP_ABORT  = 1;

endpackage

// File: rtl/blit_cmd_ctrl_if.sv
// GPU strobe/data and blitter handshake bundle for blit_cmd_ctrl.
// master = GPU decoder + blitter datapath side, slave = the sequencer.
interface blit_cmd_ctrl_if #(
    parameter int unsigned CMD_W = 32
) ();

    logic             cmdld;
    logic             stopld;
    logic             statrd;
    logic [CMD_W-1:0] gpu_din;
    logic             blit_done;
    logic             blit_collide;

    logic [CMD_W-1:0] cmd_reg;
    logic             blit_start;
    logic             blit_resume;
    logic             blit_abort;
    logic             blit_active;
    logic             blit_irq;
    logic [CMD_W-1:0] stat_dout;

    modport master (
        output cmdld, stopld, statrd, gpu_din, blit_done, blit_collide,
        input  cmd_reg, blit_start, blit_resume, blit_abort, blit_active, blit_irq, stat_dout
    );

    modport slave (
        input  cmdld, stopld, statrd, gpu_din, blit_done, blit_collide,
        output cmd_reg, blit_start, blit_resume, blit_abort, blit_active, blit_irq, stat_dout
    );

endinterface

// File: rtl/blit_cmd_ctrl_run_counter.sv
// Saturating run-cycle counter: clear has priority, then count while enabled,
// holding at all-ones once reached.
module blit_run_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/blit_cmd_ctrl.sv
// Blitter command/status sequencer: latches the command word, launches and
// tracks a blit, handles collision-stop with resume/abort, exposes status.
module blit_cmd_ctrl
    import blit_pkg::*;
#(
    parameter int unsigned CMD_W      = 32,
    parameter int unsigned STOPEN_BIT = 2,
    parameter int unsigned CNT_W      = 16
) (
    input logic         sys_clk,
    input logic         reset,
    blit_cmd_ctrl_if.slave bus
);

    blit_state_e      state_q, state_d;
    logic [CMD_W-1:0] cmd_reg_q, cmd_reg_d;
    logic             ovr_q, ovr_d;
    logic             start_q, start_d;
    logic             resume_q, resume_d;
    logic             abort_q, abort_d;
    logic             irq_q, irq_d;
    logic             cnt_clr, cnt_en;
    logic [CNT_W-1:0] cnt;

    logic stop_abort, stop_resume;
    assign stop_abort  = bus.stopld && bus.gpu_din[STOP_ABORT];
    assign stop_resume = bus.stopld && bus.gpu_din[STOP_RESUME];

    // State register
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (bus.cmdld) state_d = StStart;
            end
            StStart: begin
                state_d = StRun;
            end
            StRun: begin
                // Completion beats a same-cycle collision.
                if (bus.blit_done) begin
                    state_d = StIdle;
                end else if (bus.blit_collide && cmd_reg_q[STOPEN_BIT]) begin
                    state_d = StStopped;
                end
            end
            StStopped: begin
                if (stop_abort) begin
                    state_d = StIdle;
                end else if (stop_resume) begin
                    state_d = StRun;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output / datapath next-state logic
    always_comb begin
        start_d   = (state_q == StIdle) && bus.cmdld;
        resume_d  = (state_q == StStopped) && stop_resume && !stop_abort;
        abort_d   = (state_q == StStopped) && stop_abort;
        irq_d     = (state_q == StRun) && bus.blit_done;
        cmd_reg_d = start_d ? bus.gpu_din : cmd_reg_q;
        // A new overrun in the statrd cycle keeps the sticky bit set.
        ovr_d     = (bus.cmdld && (state_q != StIdle)) || (ovr_q && !bus.statrd);
        cnt_clr   = start_d;
        cnt_en    = (state_q == StRun);
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            cmd_reg_q <= '0;
            ovr_q     <= 1'b0;
            start_q   <= 1'b0;
            resume_q  <= 1'b0;
            abort_q   <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            cmd_reg_q <= cmd_reg_d;
            ovr_q     <= ovr_d;
            start_q   <= start_d;
            resume_q  <= resume_d;
            abort_q   <= abort_d;
            irq_q     <= irq_d;
        end
    end

    blit_run_counter #(
        .CNT_W (CNT_W)
    ) u_run_counter (
        .clk_i (sys_clk),
        .rst_i (reset),
        .clr_i (cnt_clr),
        .en_i  (cnt_en),
        .cnt_o (cnt)
    );

    always_comb begin
        bus.stat_dout                         = '0;
        bus.stat_dout[ST_IDLE]                = (state_q == StIdle);
        bus.stat_dout[ST_STOPPED]             = (state_q == StStopped);
        bus.stat_dout[ST_OVERRUN]             = ovr_q;
        bus.stat_dout[ST_CNT_LSB +: CNT_W]    = cnt;
    end

    assign bus.cmd_reg     = cmd_reg_q;
    assign bus.blit_start  = start_q;
    assign bus.blit_resume = resume_q;
    assign bus.blit_abort  = abort_q;
    assign bus.blit_irq    = irq_q;
    assign bus.blit_active = (state_q != StIdle);

endmodule

// File: tb/tb_blit_cmd_ctrl.sv
// Directed bench for blit_cmd_ctrl: a vector table of per-cycle stimulus and
// expected outputs, plus sequences for counter saturation and async reset.
module tb_blit_cmd_ctrl;

    localparam logic [4:0] P_NONE = 5'b00000;
    localparam logic [4:0] P_ACT  = 5'b00001;
    localparam logic [4:0] P_IRQ  = 5'b00010;
    localparam logic [4:0] P_ABT  = 5'b00100;
    localparam logic [4:0] P_RES  = 5'b01000;
    localparam logic [4:0] P_STA  = 5'b10000;

    typedef struct {
        logic        cmdld;
        logic        stopld;
        logic        statrd;
        logic [31:0] din;
        logic        done;
        logic        coll;
        logic [4:0]  exp_p;    // {start, resume, abort, irq, active}
        logic [31:0] exp_cmd;
        logic [31:0] exp_stat;
    } vec_t;

    logic sys_clk = 1'b0;
    logic reset   = 1'b1;
    int   n_cmp   = 0;
    int   n_fail  = 0;
    vec_t vecs[$];

    always #5 sys_clk = ~sys_clk;

    blit_cmd_ctrl_if #(.CMD_W(32)) bus ();

    blit_cmd_ctrl #(
        .CMD_W      (32),
        .STOPEN_BIT (2),
        .CNT_W      (16)
    ) dut (
        .sys_clk (sys_clk),
        .reset   (reset),
        .bus     (bus)
    );

    function automatic logic [31:0] st(int cnt, bit ovr, bit stp, bit idl);
        logic [31:0] c;
        c = cnt;
        return {c[15:0], 13'b0, ovr, stp, idl};
    endfunction

    task automatic add(input logic c, input logic s, input logic r, input logic [31:0] d,
                       input logic dn, input logic co, input logic [4:0] p,
                       input logic [31:0] cmd, input logic [31:0] stat);
        vec_t v;
        v.cmdld = c; v.stopld = s; v.statrd = r; v.din = d; v.done = dn; v.coll = co;
        v.exp_p = p; v.exp_cmd = cmd; v.exp_stat = stat;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pulses();
        return {27'b0, bus.blit_start, bus.blit_resume, bus.blit_abort, bus.blit_irq,
                bus.blit_active};
    endfunction

    task automatic check_all(input string tag, input logic [4:0] p, input logic [31:0] cmd,
                             input logic [31:0] stat);
        check({tag, ".pulses"}, pulses(), {27'b0, p});
        check({tag, ".cmd_reg"}, bus.cmd_reg, cmd);
        check({tag, ".stat"}, bus.stat_dout, stat);
    endtask

    task automatic drive_idle();
        bus.cmdld = 0; bus.stopld = 0; bus.statrd = 0; bus.gpu_din = '0;
        bus.blit_done = 0; bus.blit_collide = 0;
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    initial begin
        drive_idle();

        // Launch and complete, done 10 cycles after blit_start
        add(1,0,0,32'h4,0,0, P_STA|P_ACT, 4, st(0,0,0,0));
        add(0,0,0,0,0,0, P_ACT, 4, st(0,0,0,0));
        for (int i = 1; i <= 9; i++) add(0,0,0,0,0,0, P_ACT, 4, st(i,0,0,0));
        add(0,0,0,0,1,0, P_IRQ, 4, st(10,0,0,1));
        add(0,0,0,0,0,0, P_NONE, 4, st(10,0,0,1));
        // Collision stop, ignored stopld=0, resume, then done
        add(1,0,0,32'h4,0,0, P_STA|P_ACT, 4, st(0,0,0,0));
        add(0,0,0,0,0,0, P_ACT, 4, st(0,0,0,0));
        add(0,0,0,0,0,0, P_ACT, 4, st(1,0,0,0));
        add(0,0,0,0,0,1, P_ACT, 4, st(2,0,1,0));
        add(0,0,0,0,0,0, P_ACT, 4, st(2,0,1,0));
        add(0,1,0,32'h0,0,0, P_ACT, 4, st(2,0,1,0));
        add(0,1,0,32'h1,0,0, P_RES|P_ACT, 4, st(2,0,0,0));
        add(0,0,0,0,0,0, P_ACT, 4, st(3,0,0,0));
        add(0,0,0,0,1,0, P_IRQ, 4, st(4,0,0,1));
        // Abort beats resume
        add(1,0,0,32'h4,0,0, P_STA|P_ACT, 4, st(0,0,0,0));
        add(0,0,0,0,0,0, P_ACT, 4, st(0,0,0,0));
        add(0,0,0,0,0,1, P_ACT, 4, st(1,0,1,0));
        add(0,1,0,32'h3,0,0, P_ABT, 4, st(1,0,0,1));
        add(0,0,0,0,0,0, P_NONE, 4, st(1,0,0,1));
        // Collision with stop disabled; stopld in RUN ignored
        add(1,0,0,32'h0,0,0, P_STA|P_ACT, 0, st(0,0,0,0));
        add(0,0,0,0,0,0, P_ACT, 0, st(0,0,0,0));
        add(0,0,0,0,0,1, P_ACT, 0, st(1,0,0,0));
        add(0,1,0,32'h1,0,0, P_ACT, 0, st(2,0,0,0));
        add(0,0,0,0,1,0, P_IRQ, 0, st(3,0,0,1));
        // Done wins over collision
        add(1,0,0,32'h4,0,0, P_STA|P_ACT, 4, st(0,0,0,0));
        add(0,0,0,0,0,0, P_ACT, 4, st(0,0,0,0));
        add(0,0,0,0,1,1, P_IRQ, 4, st(1,0,0,1));
        add(0,0,0,0,0,0, P_NONE, 4, st(1,0,0,1));
        // Overrun sticky, read-clear, and coincident set
        add(1,0,0,32'h4,0,0, P_STA|P_ACT, 4, st(0,0,0,0));
        add(1,0,0,32'hFFFF,0,0, P_ACT, 4, st(0,1,0,0));
        add(1,0,0,32'hFFFF,0,0, P_ACT, 4, st(1,1,0,0));
        add(0,0,1,0,0,0, P_ACT, 4, st(2,0,0,0));
        add(1,0,1,32'hFFFF,0,0, P_ACT, 4, st(3,1,0,0));
        add(0,0,0,0,0,0, P_ACT, 4, st(4,1,0,0));
        add(0,0,1,0,0,0, P_ACT, 4, st(5,0,0,0));
        add(0,0,0,0,1,0, P_IRQ, 4, st(6,0,0,1));
        add(0,1,0,32'h3,0,0, P_NONE, 4, st(6,0,0,1));
        // Overrun while stopped, then abort and read-clear
        add(1,0,0,32'h4,0,0, P_STA|P_ACT, 4, st(0,0,0,0));
        add(0,0,0,0,0,0, P_ACT, 4, st(0,0,0,0));
        add(0,0,0,0,0,1, P_ACT, 4, st(1,0,1,0));
        add(1,0,0,32'hFFFF,0,0, P_ACT, 4, st(1,1,1,0));
        add(0,1,0,32'h2,0,0, P_ABT, 4, st(1,1,0,1));
        add(0,0,1,0,0,0, P_NONE, 4, st(1,0,0,1));

        // Reset state
        step();
        step();
        check_all("reset", P_NONE, 32'h0, 32'h1);
        reset = 1'b0;
        step();
        check_all("post_reset", P_NONE, 32'h0, 32'h1);

        foreach (vecs[i]) begin
            bus.cmdld = vecs[i].cmdld;   bus.stopld = vecs[i].stopld;
            bus.statrd = vecs[i].statrd; bus.gpu_din = vecs[i].din;
            bus.blit_done = vecs[i].done; bus.blit_collide = vecs[i].coll;
            step();
            check_all($sformatf("vec%0d", i), vecs[i].exp_p, vecs[i].exp_cmd, vecs[i].exp_stat);
        end
        drive_idle();

        // Counter saturation over a long run
        bus.cmdld = 1; bus.gpu_din = 32'h4;
        step();
        drive_idle();
        step();
        check_all("sat_enter", P_ACT, 4, st(0,0,0,0));
        for (int k = 1; k <= 70000; k++) begin
            step();
            if (k == 65534) check("sat_pre", bus.stat_dout, 32'hFFFE0000);
            if (k == 65535) check("sat_hit", bus.stat_dout, 32'hFFFF0000);
        end
        check_all("sat_hold", P_ACT, 4, 32'hFFFF0000);

        // Async reset mid-RUN, away from any clock edge
        #3 reset = 1'b1;
        #1;
        check_all("async_reset", P_NONE, 32'h0, 32'h1);
        step();
        check_all("reset_hold1", P_NONE, 32'h0, 32'h1);
        step();
        check_all("reset_hold2", P_NONE, 32'h0, 32'h1);
        reset = 1'b0;
        step();
        check_all("reset_release", P_NONE, 32'h0, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
